// File: rtl/prescription_pkg.sv
// Shared constants for the prescription ROM subsystem: ROM geometry, read pipeline
// depth and the fixed requester indices used on the arbiter ports.
package prescription_pkg;

    localparam int ROM_ADDR_W       = 8;
    localparam int ROM_DATA_W       = 28;
    localparam int ROM_READ_LATENCY = 1;
    localparam int PIPE_DEPTH       = 1 + ROM_READ_LATENCY;

    localparam int REQ_CONTROL    = 0;
    localparam int REQ_MONITOR    = 1;
    localparam int REQ_LCD        = 2;
    localparam int NUM_REQUESTERS = REQ_LCD + 1;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: one-hot grant to the first set request bit found
// searching upward from ptr, wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // NOTE: every variable gets a default before the loop so no path can leave it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing the single-port prescription ROM between Control,
// NextPillMonitor and LCD, with an optional bounded burst lock and owner-tagged responses.
module rom_access_arbiter
    import prescription_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQUESTERS,
    parameter int ADDR_W       = ROM_ADDR_W,
    parameter int DATA_W       = ROM_DATA_W,
    parameter int READ_LATENCY = ROM_READ_LATENCY,
    parameter int MAX_BURST    = 16
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [NUM_REQ-1:0]        reqValid,
    input  logic [NUM_REQ*ADDR_W-1:0] reqAddr,
    input  logic [NUM_REQ-1:0]        reqLock,
    output logic [NUM_REQ-1:0]        reqReady,
    output logic [ADDR_W-1:0]         romAddr,
    input  logic [DATA_W-1:0]         romData,
    output logic [NUM_REQ-1:0]        rspValid,
    output logic [DATA_W-1:0]         rspData,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int DEPTH = 1 + READ_LATENCY;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    logic [PTR_W-1:0]   ptr, lock_owner, hold_id, acc_idx;
    logic               lock_active, hold_block;
    logic [CNT_W-1:0]   burst_cnt, next_cnt;
    logic [NUM_REQ-1:0] rr_grant, owner_mask, acc_mask;
    logic               owner_go, accept, others_pending, relock_ok, want_lock, burst_end;
    logic [DEPTH-1:0]   pipe_valid;
    logic [PTR_W-1:0]   pipe_id [DEPTH];

    rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
        .req   (reqValid),
        .ptr   (ptr),
        .grant (rr_grant)
    );

    always_comb begin
        owner_mask = NUM_REQ'(1) << lock_owner;
        owner_go   = lock_active && reqValid[lock_owner];
        reqReady   = owner_go ? owner_mask : rr_grant;
        accept     = |reqReady;
        acc_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reqReady[i]) acc_idx = PTR_W'(i);
        end
        acc_mask       = NUM_REQ'(1) << acc_idx;
        others_pending = |(reqValid & ~acc_mask);
        // An owner cut off by MAX_BURST may not relock while anyone else is waiting.
        relock_ok = !(hold_block && (hold_id == acc_idx) && others_pending);
        want_lock = accept && reqLock[acc_idx] && relock_ok;
        next_cnt  = owner_go ? burst_cnt + 1'b1 : CNT_W'(1);
        burst_end = want_lock && (next_cnt == CNT_W'(MAX_BURST));
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            romAddr     <= '0;
            ptr         <= '0;
            lock_active <= 1'b0;
            lock_owner  <= '0;
            burst_cnt   <= '0;
            hold_block  <= 1'b0;
            hold_id     <= '0;
        end else if (accept) begin
            romAddr    <= reqAddr[acc_idx*ADDR_W +: ADDR_W];
            hold_block <= burst_end;
            hold_id    <= acc_idx;
            if (want_lock && !burst_end) begin
                lock_active <= 1'b1;
                lock_owner  <= acc_idx;
                burst_cnt   <= next_cnt;
            end else begin
                lock_active <= 1'b0;
                burst_cnt   <= '0;
                ptr         <= next_idx(acc_idx);
            end
        end else if (lock_active && !reqValid[lock_owner]) begin
            lock_active <= 1'b0;
            burst_cnt   <= '0;
        end
    end

    // The owner tag travels alongside the ROM read so responses come back in order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pipe_valid <= '0;
            for (int s = 0; s < DEPTH; s++) pipe_id[s] <= '0;
        end else begin
            pipe_valid[0] <= accept;
            pipe_id[0]    <= acc_idx;
            for (int s = 1; s < DEPTH; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_id[s]    <= pipe_id[s-1];
            end
        end
    end

    always_comb begin
        rspValid = pipe_valid[DEPTH-1] ? (NUM_REQ'(1) << pipe_id[DEPTH-1]) : '0;
        rspData  = romData;
        busy     = |pipe_valid;
    end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Self-checking bench for rom_access_arbiter: a vector table for single reads,
// contention and wrap, then hand sequences for burst lock, withdrawal and reset.
module tb_rom_access_arbiter;
    import prescription_pkg::*;

    logic        clk = 1'b0;
    logic        resetN;
    logic [2:0]  reqValid, reqLock, reqReady, rspValid;
    logic [23:0] reqAddr;
    logic [7:0]  romAddr;
    logic [27:0] romData, rspData, rom_q;
    logic        busy;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rom_access_arbiter dut (
        .clk      (clk),
        .resetN   (resetN),
        .reqValid (reqValid),
        .reqAddr  (reqAddr),
        .reqLock  (reqLock),
        .reqReady (reqReady),
        .romAddr  (romAddr),
        .romData  (romData),
        .rspValid (rspValid),
        .rspData  (rspData),
        .busy     (busy)
    );

    function automatic logic [27:0] rom_word(input logic [7:0] a);
        return (a == 8'h05) ? 28'h1234567 : {4'hC, a, ~a, a ^ 8'h3C};
    endfunction

    always @(posedge clk) rom_q <= rom_word(romAddr);
    assign romData = rom_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  valid;
        logic [23:0] addr;
        logic [2:0]  lock;
        logic [2:0]  exp_ready;
        logic [7:0]  exp_rom_addr;
        logic [2:0]  exp_rsp;
        logic [27:0] exp_data;
        logic        exp_busy;
        string       name;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] v, input logic [23:0] a, input logic [2:0] rdy,
                                input logic [7:0] ra, input logic [2:0] rsp, input logic [27:0] d,
                                input logic bsy, input string name);
        vec_t r;
        r.valid = v; r.addr = a; r.lock = 3'b000; r.exp_ready = rdy; r.exp_rom_addr = ra;
        r.exp_rsp = rsp; r.exp_data = d; r.exp_busy = bsy; r.name = name;
        return r;
    endfunction

    // Reference model for the hand sequences, advanced from the expected grants only.
    logic       h_valid [PIPE_DEPTH];
    logic [1:0] h_id    [PIPE_DEPTH];
    logic [7:0] h_addr  [PIPE_DEPTH];
    logic [7:0] m_rom_addr;

    task automatic model_clear(input logic [7:0] rom_addr);
        for (int s = 0; s < PIPE_DEPTH; s++) begin
            h_valid[s] = 1'b0; h_id[s] = 2'd0; h_addr[s] = 8'h00;
        end
        m_rom_addr = rom_addr;
    endtask

    task automatic step(input logic [2:0] v, input logic [23:0] a, input logic [2:0] l,
                        input logic [2:0] exp_ready, input string name);
        logic [2:0] exp_rsp;
        logic       exp_busy;
        int         id;
        @(negedge clk);
        reqValid = v; reqAddr = a; reqLock = l;
        #2;
        exp_rsp  = h_valid[PIPE_DEPTH-1] ? (3'b001 << h_id[PIPE_DEPTH-1]) : 3'b000;
        exp_busy = 1'b0;
        for (int s = 0; s < PIPE_DEPTH; s++) exp_busy = exp_busy | h_valid[s];
        check({name, " ready"}, 32'(reqReady), 32'(exp_ready));
        check({name, " romAddr"}, 32'(romAddr), 32'(m_rom_addr));
        check({name, " rspValid"}, 32'(rspValid), 32'(exp_rsp));
        check({name, " busy"}, 32'(busy), 32'(exp_busy));
        if (exp_rsp != 3'b000)
            check({name, " rspData"}, 32'(rspData), 32'(rom_word(h_addr[PIPE_DEPTH-1])));
        for (int s = PIPE_DEPTH - 1; s > 0; s--) begin
            h_valid[s] = h_valid[s-1]; h_id[s] = h_id[s-1]; h_addr[s] = h_addr[s-1];
        end
        id = 0;
        for (int i = 0; i < 3; i++) if (exp_ready[i]) id = i;
        h_valid[0] = (exp_ready != 3'b000);
        h_id[0]    = 2'(id);
        h_addr[0]  = a[id*8 +: 8];
        if (exp_ready != 3'b000) m_rom_addr = a[id*8 +: 8];
    endtask

    vec_t vecs [18];

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t, want finished", $time);
        $fatal(1);
    end

    initial begin
        logic [2:0] exp;
        int         n2;

        vecs[0]  = mk(3'b000, 24'h000000, 3'b000, 8'h00, 3'b000, 28'h0, 1'b0, "reset state");
        vecs[1]  = mk(3'b010, 24'h000500, 3'b010, 8'h00, 3'b000, 28'h0, 1'b0, "single accept");
        vecs[2]  = mk(3'b000, 24'h000000, 3'b000, 8'h05, 3'b000, 28'h0, 1'b1, "single romAddr");
        vecs[3]  = mk(3'b000, 24'h000000, 3'b000, 8'h05, 3'b010, 28'h1234567, 1'b1, "single rsp");
        vecs[4]  = mk(3'b100, 24'h300000, 3'b100, 8'h05, 3'b000, 28'h0, 1'b0, "ptr to 0");
        vecs[5]  = mk(3'b111, 24'h302010, 3'b001, 8'h30, 3'b000, 28'h0, 1'b1, "cont g0");
        vecs[6]  = mk(3'b111, 24'h302010, 3'b010, 8'h10, 3'b100, rom_word(8'h30), 1'b1, "cont g1");
        vecs[7]  = mk(3'b111, 24'h302010, 3'b100, 8'h20, 3'b001, rom_word(8'h10), 1'b1, "cont g2");
        vecs[8]  = mk(3'b111, 24'h302010, 3'b001, 8'h30, 3'b010, rom_word(8'h20), 1'b1, "cont g0 again");
        vecs[9]  = mk(3'b000, 24'h000000, 3'b000, 8'h10, 3'b100, rom_word(8'h30), 1'b1, "cont drain a");
        vecs[10] = mk(3'b000, 24'h000000, 3'b000, 8'h10, 3'b001, rom_word(8'h10), 1'b1, "cont drain b");
        vecs[11] = mk(3'b010, 24'h004400, 3'b010, 8'h10, 3'b000, 28'h0, 1'b0, "ptr to 2");
        vecs[12] = mk(3'b101, 24'h520050, 3'b100, 8'h44, 3'b000, 28'h0, 1'b1, "wrap g2");
        vecs[13] = mk(3'b101, 24'h520050, 3'b001, 8'h52, 3'b010, rom_word(8'h44), 1'b1, "wrap g0");
        vecs[14] = mk(3'b101, 24'h520050, 3'b100, 8'h50, 3'b100, rom_word(8'h52), 1'b1, "wrap ptr 1");
        vecs[15] = mk(3'b000, 24'h000000, 3'b000, 8'h52, 3'b001, rom_word(8'h50), 1'b1, "wrap drain a");
        vecs[16] = mk(3'b000, 24'h000000, 3'b000, 8'h52, 3'b100, rom_word(8'h52), 1'b1, "wrap drain b");
        vecs[17] = mk(3'b000, 24'h000000, 3'b000, 8'h52, 3'b000, 28'h0, 1'b0, "idle");

        resetN = 1'b0; reqValid = 3'b000; reqAddr = 24'h0; reqLock = 3'b000;
        repeat (3) @(negedge clk);
        resetN = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            reqValid = vecs[i].valid; reqAddr = vecs[i].addr; reqLock = vecs[i].lock;
            #2;
            check({vecs[i].name, " ready"}, 32'(reqReady), 32'(vecs[i].exp_ready));
            check({vecs[i].name, " romAddr"}, 32'(romAddr), 32'(vecs[i].exp_rom_addr));
            check({vecs[i].name, " rspValid"}, 32'(rspValid), 32'(vecs[i].exp_rsp));
            check({vecs[i].name, " busy"}, 32'(busy), 32'(vecs[i].exp_busy));
            if (vecs[i].exp_rsp != 3'b000)
                check({vecs[i].name, " rspData"}, 32'(rspData), 32'(vecs[i].exp_data));
        end
        model_clear(8'h52);

        // LCD locks with 20 reads while Control waits: 16 grants, one to Control, LCD resumes.
        step(3'b010, 24'h000100, 3'b000, 3'b010, "lock setup");
        n2 = 0;
        for (int k = 0; k <= 20; k++) begin
            exp = (k == 16) ? 3'b001 : 3'b100;
            step(3'b101, {8'(8'h80 + n2), 8'h00, 8'h60}, 3'b100, exp, $sformatf("lock k=%0d", k));
            if (exp == 3'b100) n2++;
        end
        step(3'b001, 24'h000060, 3'b000, 3'b001, "lock release");

        // Control withdraws while NextPillMonitor holds the lock.
        step(3'b010, 24'h009000, 3'b010, 3'b010, "wd lock");
        for (int k = 0; k < 3; k++)
            step(3'b011, 24'h00910F, 3'b010, 3'b010, $sformatf("wd pend %0d", k));
        for (int k = 0; k < 2; k++)
            step(3'b010, 24'h009200, 3'b010, 3'b010, $sformatf("wd drop %0d", k));
        step(3'b000, 24'h000000, 3'b000, 3'b000, "wd owner idle");
        step(3'b000, 24'h000000, 3'b000, 3'b000, "wd drain a");
        step(3'b000, 24'h000000, 3'b000, 3'b000, "wd drain b");

        // Reset one cycle after acceptance: the in-flight response is discarded.
        step(3'b001, 24'h000070, 3'b000, 3'b001, "rst accept");
        @(negedge clk);
        reqValid = 3'b000;
        #2;
        check("rst pre romAddr", 32'(romAddr), 32'h70);
        check("rst pre busy", 32'(busy), 32'h1);
        resetN = 1'b0;
        #1;
        check("rst romAddr", 32'(romAddr), 32'h0);
        check("rst rspValid", 32'(rspValid), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #2;
            check($sformatf("rst hold rspValid %0d", k), 32'(rspValid), 32'h0);
        end
        resetN = 1'b1;
        model_clear(8'h00);
        step(3'b101, 24'h720071, 3'b000, 3'b001, "post-rst grant");
        for (int k = 0; k < 3; k++)
            step(3'b000, 24'h000000, 3'b000, 3'b000, $sformatf("post-rst drain %0d", k));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
